seg_scan_driver: RTL
====================

# seg_scan_driver

Time-multiplexed driver for a bank of common-anode seven-segment digits, generalising the single-digit hex decoder to DIGITS digits with a shared segment bus. It captures a packed hex value and decimal points on a load strobe, then scans one digit at a time. Its outputs are registered and drive the board pins directly. It adds leading-zero suppression, anti-ghosting guard time, output enable and selectable output polarity.

## Interface
- DIGITS, 4: number of digits; range 2-8.
- SCAN_DIV, 50000: clock cycles each digit stays selected; must be at least 4.
- GUARD, 2: cycles at the start of each slot with all anodes inactive; 1 ≤ GUARD < SCAN_DIV.
- ACTIVE_LOW, 1: 1 means seg, dp_out and an are active-low; 0 inverts all three.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- load  in  1  capture value and dp into the shadow registers.
- value  in  4*DIGITS  hex nibbles; digit i is value[4i+3:4i]; digit 0 is least significant and rightmost.
- dp  in  DIGITS  decimal point per digit; 1 = lit.
- lz_en  in  1  enable leading-zero suppression.
- enable  in  1  display on; 0 forces all outputs inactive.
- seg  out  7  segments {g,f,e,d,c,b,a}.
- dp_out  out  1  decimal-point segment.
- an  out  DIGITS  digit selects, one-hot-active.
- digit_idx  out  $clog2(DIGITS)  index of the currently scanned digit (unregistered state, for debug and verification).

## Operation
- **Shadow registers.** On each rising edge with load=1, value and dp are copied into the shadow registers. Display never reads value or dp directly.
- **Prescaler.** pre counts 0..SCAN_DIV-1 and wraps. When pre wraps, idx advances; idx wraps from DIGITS-1 to 0.
- **Segment decode.** Active-low codes for nibbles 0-F, in order: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex). With ACTIVE_LOW=0 these codes are bitwise inverted.
- **Leading-zero suppression.** Active when lz_en=1. Digit i is suppressed when i>0 and shadow nibbles i..DIGITS-1 are all zero. A suppressed digit shows all segments inactive and dp inactive, but its anode is still driven. Digit 0 is never suppressed. All-zero input therefore displays a single "0".
- **Guard time.** While pre < GUARD, every an bit is inactive. seg and dp_out already carry the new digit during this window.
- **Enable.** enable=0 drives all outputs inactive. Prescaler, idx and shadow registers keep running and updating.
- **Inactive level.** Inactive means logic 1 when ACTIVE_LOW=1 and logic 0 when ACTIVE_LOW=0.

## Timing
- **Reset.** While rst=1: shadow value=0, shadow dp=0, pre=0, idx=0. seg, dp_out and an are all inactive (with ACTIVE_LOW=1: seg=7F, dp_out=1, an all ones). Reset takes effect immediately, without waiting for a clock edge, including mid-scan or mid-load.
- **Output registers.** seg, dp_out and an are registered. The value present after edge k is computed from pre, idx, the shadow registers, lz_en and enable as they stood before edge k. This gives a fixed one-cycle lag behind the internal state.
- **Load latency.** load sampled at edge N updates the shadow at edge N. The new data reaches the pins at edge N+1, provided its digit is the one being scanned.
- **Load on a digit boundary.** If load coincides with the idx advance, the output at the next edge uses the new idx with the new shadow data.
- **Back-to-back loads.** Load held high captures every cycle; the last captured value wins.
- **Scan period.** A full scan takes DIGITS*SCAN_DIV cycles. Each digit's anode is active for SCAN_DIV-GUARD consecutive cycles per scan.
- **Input sampling.** lz_en and enable are sampled every cycle. They need no synchronisation beyond clk.

## Test plan
- **Reset.** Bench parameters: DIGITS=4, SCAN_DIV=8, GUARD=2, ACTIVE_LOW=1. Assert rst asynchronously mid-slot -> same cycle, seg=7F, dp_out=1, an=1111; after release, idx=0 and the first active anode is an=1110 at output cycle 3.
- **Scan order.** Load value=16'h1234 -> an visits 1110,1101,1011,0111 in order, each low for 6 of 8 cycles with 2 all-high cycles between. seg shows 19,30,24,79 respectively (digits 4,3,2,1).
- **Decode table and decimal points.** Load each nibble 0-F into digit 0 -> seg matches the code table. Load dp=4'b0101 -> dp_out=0 only on digits 0 and 2.
- **Leading-zero suppression.** With lz_en=1: value=16'h0050 -> digits 3 and 2 show seg=7F with their anodes still driven; digit 1 shows 12 and digit 0 shows 40. value=0 -> only digit 0 shows 40. With lz_en=0, value=0 -> all digits show 40.
- **Enable and load timing.** Drop enable for 20 cycles -> an=1111, seg=7F, while idx keeps advancing. Pulse load on the cycle idx advances -> the new nibble appears one cycle later on the new digit.
- **Inverted polarity.** ACTIVE_LOW=0 -> reset outputs are all 0; digit 0 of 8 shows seg=7F; an is active-high one-hot.

Source files
------------

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - time-multiplexed seven-segment scan driver
// Shadowed hex/dp capture, per-digit scan with guard time, leading-zero blanking, registered pins.
module seg_scan_driver #(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int GUARD      = 2,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        load_i,
    input  logic [4*DIGITS-1:0]         value_i,
    input  logic [DIGITS-1:0]           dp_i,
    input  logic                        lz_en_i,
    input  logic                        enable_i,
    output logic [6:0]                  seg_o,
    output logic                        dp_out_o,
    output logic [DIGITS-1:0]           an_o,
    output logic [$clog2(DIGITS)-1:0]   digit_idx_o
);
    localparam int   IW  = $clog2(DIGITS);
    localparam int   PW  = $clog2(SCAN_DIV);
    localparam logic INV = (ACTIVE_LOW != 0);

    logic [4*DIGITS-1:0] val_q;
    logic [DIGITS-1:0]   dp_q;
    logic [PW-1:0]       pre_q, pre_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_out_q, dp_out_d;
    logic [DIGITS-1:0]   an_q, an_d;

    logic [3:0]          nib_sel;
    logic                dp_sel;
    logic                zero_run;
    logic                supp;
    logic                blank;
    logic [6:0]          seg_lit;
    logic                dp_lit;
    logic [DIGITS-1:0]   an_lit;

    // Codes are stored active-low; lit-high versions are derived below.
    function automatic logic [6:0] hex_code(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    always_comb begin
        pre_d = pre_q + PW'(1);
        idx_d = idx_q;
        if (pre_q == PW'(SCAN_DIV - 1)) begin
            pre_d = '0;
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
    end

    always_comb begin
        nib_sel  = '0;
        dp_sel   = 1'b0;
        zero_run = 1'b1;
        supp     = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                nib_sel = val_q[4*i +: 4];
                dp_sel  = dp_q[i];
            end
        end
        // Walk from the most significant digit down; digit 0 is never blanked.
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_run = zero_run & (val_q[4*i +: 4] == 4'h0);
            if (idx_q == IW'(i) && zero_run)
                supp = lz_en_i;
        end
        blank   = ~enable_i | supp;
        seg_lit = blank ? 7'h00 : ~hex_code(nib_sel);
        dp_lit  = ~blank & dp_sel;
        an_lit  = (enable_i && pre_q >= PW'(GUARD)) ? (DIGITS'(1) << idx_q) : '0;
        seg_d    = INV ? ~seg_lit : seg_lit;
        dp_out_d = INV ? ~dp_lit  : dp_lit;
        an_d     = INV ? ~an_lit  : an_lit;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            val_q    <= '0;
            dp_q     <= '0;
            pre_q    <= '0;
            idx_q    <= '0;
            seg_q    <= {7{INV}};
            dp_out_q <= INV;
            an_q     <= {DIGITS{INV}};
        end else begin
            if (load_i) begin
                val_q <= value_i;
                dp_q  <= dp_i;
            end
            pre_q    <= pre_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            dp_out_q <= dp_out_d;
            an_q     <= an_d;
        end
    end

    assign seg_o       = seg_q;
    assign dp_out_o    = dp_out_q;
    assign an_o        = an_q;
    assign digit_idx_o = idx_q;

endmodule
